// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall controller.
package pipe_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  // Default number of stall cycles for a multi-cycle EX operation
  localparam int MUL_CYCLES_DEF = 4;
  // Default width of the stall-cycle performance counter
  localparam int PERF_W_DEF     = 16;
  // Width of the multi-cycle countdown (MUL_CYCLES tops out at 15)
  localparam int MUL_CNT_W      = 4;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Increment on enable, never wrap past all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (en && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order pipeline.
// Memory stalls freeze the whole pipe and win over everything; multi-cycle
// EX ops freeze the front end for MUL_CYCLES cycles; load-use inserts a
// single EX bubble; taken branches flush IF/ID when nothing is held.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int PERF_W     = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use,
  input  logic              branch_taken,
  input  logic              mul_start,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              hold_pc,
  output logic              hold_if,
  output logic              hold_id,
  output logic              hold_ex,
  output logic              hold_mem,
  output logic              flush_if,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic              bubble_wb,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cycles
);

  // The countdown only has MUL_CNT_W bits, so reject unsupported lengths.
  if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("pipe_stall_ctrl: MUL_CYCLES must be in 2..15");
  end

  // First stall cycle happens in RUN, so the countdown covers the rest.
  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 1);

  ctrl_state_t          state_reg, state_next;
  logic [MUL_CNT_W-1:0] cnt_reg, cnt_next;

  logic mem_stall;
  logic mem_hold;   // whole pipe frozen, WB bubbled
  logic mul_hold;   // front end frozen behind the multi-cycle op
  logic lu_hold;    // one-cycle load-use bubble
  logic br_flush;   // squash the wrong-path fetch

  assign mem_stall = mem_req && !mem_ack;

  // State and multi-cycle countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and stall-class decode; rst masks every control output
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_hold   = 1'b0;
    mul_hold   = 1'b0;
    lu_hold    = 1'b0;
    br_flush   = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (mem_stall) begin
          mem_hold   = 1'b1;
          state_next = MEM_WAIT;
        end else if (mul_start) begin
          mul_hold   = 1'b1;
          cnt_next   = MUL_LOAD;
          state_next = MUL_WAIT;
        end else if (load_use) begin
          // Load-use beats a same-cycle branch: ID is held, so the branch
          // is seen again next cycle.
          lu_hold = 1'b1;
        end else if (branch_taken) begin
          br_flush = 1'b1;
        end
      end

      MUL_WAIT: begin
        if (cnt_reg != '0) begin
          // Keep counting through memory stalls so the op length is fixed.
          cnt_next = cnt_reg - MUL_CNT_W'(1);
          if (mem_stall) begin
            mem_hold = 1'b1;
          end else begin
            mul_hold = 1'b1;
          end
        end else if (mem_stall) begin
          mem_hold   = 1'b1;
          state_next = MEM_WAIT;
        end else begin
          state_next = RUN;
        end
      end

      MEM_WAIT: begin
        if (!mem_ack) begin
          mem_hold = 1'b1;
        end else begin
          state_next = RUN;
        end
      end

      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase

    if (rst) begin
      mem_hold = 1'b0;
      mul_hold = 1'b0;
      lu_hold  = 1'b0;
      br_flush = 1'b0;
    end
  end

  // Map stall classes onto the per-stage controls
  always_comb begin
    hold_pc    = mem_hold || mul_hold || lu_hold;
    hold_if    = mem_hold || mul_hold || lu_hold;
    hold_id    = mem_hold || mul_hold;
    hold_ex    = mem_hold || mul_hold;
    hold_mem   = mem_hold;
    flush_if   = br_flush;
    bubble_ex  = lu_hold;
    bubble_mem = mul_hold;
    bubble_wb  = mem_hold;
    busy       = (state_reg != RUN) && !rst;
  end

  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hold_pc),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scenario bench for pipe_stall_ctrl: each step drives one cycle of inputs,
// queues the expected controls, then checks them mid-cycle.
module tb_pipe_stall_ctrl;

  localparam int PW = 5;

  // Expected-output bit positions
  localparam logic [9:0] HPC  = 10'h200;
  localparam logic [9:0] HIF  = 10'h100;
  localparam logic [9:0] HID  = 10'h080;
  localparam logic [9:0] HEX  = 10'h040;
  localparam logic [9:0] HMEM = 10'h020;
  localparam logic [9:0] FIF  = 10'h010;
  localparam logic [9:0] BEX  = 10'h008;
  localparam logic [9:0] BMEM = 10'h004;
  localparam logic [9:0] BWB  = 10'h002;
  localparam logic [9:0] BSY  = 10'h001;
  localparam logic [9:0] NONE = 10'h000;
  localparam logic [9:0] H_MUL = HPC | HIF | HID | HEX | BMEM;
  localparam logic [9:0] H_MEM = HPC | HIF | HID | HEX | HMEM | BWB;
  localparam logic [9:0] H_LU  = HPC | HIF | BEX;

  logic clk = 1'b0;
  logic rst, load_use, branch_taken, mul_start, mem_req, mem_ack;
  logic hold_pc, hold_if, hold_id, hold_ex, hold_mem;
  logic flush_if, bubble_ex, bubble_mem, bubble_wb, busy;
  logic [PW-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]    exp_q [$];
  logic [PW-1:0] sc_q  [$];
  logic [15:0]   plan  [$];   // {rst, lu, br, ms, mr, ma, expected[9:0]}
  logic [PW-1:0] sc_model = '0;
  logic [9:0]    got, e;
  logic [PW-1:0] s;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .MUL_CYCLES (4),
    .PERF_W     (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mul_start    (mul_start),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .hold_pc      (hold_pc),
    .hold_if      (hold_if),
    .hold_id      (hold_id),
    .hold_ex      (hold_ex),
    .hold_mem     (hold_mem),
    .flush_if     (flush_if),
    .bubble_ex    (bubble_ex),
    .bubble_mem   (bubble_mem),
    .bubble_wb    (bubble_wb),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  function automatic logic [9:0] outs();
    return {hold_pc, hold_if, hold_id, hold_ex, hold_mem,
            flush_if, bubble_ex, bubble_mem, bubble_wb, busy};
  endfunction

  // Apply one cycle of stimulus and queue what the spec says must come out
  task automatic drive(input logic [15:0] p);
    @(negedge clk);
    rst = p[15];
    {load_use, branch_taken, mul_start, mem_req, mem_ack} = p[14:10];
    exp_q.push_back(p[9:0]);
    sc_q.push_back(sc_model);
    if (p[15]) sc_model = '0;
    else if (p[9] && sc_model != {PW{1'b1}}) sc_model = sc_model + 1'b1;
  endtask

  task automatic test_reset();
    plan = '{ {1'b1, 5'b10110, NONE},
              {1'b1, 5'b01100, NONE},
              {1'b0, 5'b00000, NONE} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL reset step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL reset step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_load_use();
    plan = '{ {1'b0, 5'b10000, H_LU},
              {1'b0, 5'b00000, NONE},
              {1'b0, 5'b00000, NONE} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL load_use step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL load_use step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_branch();
    plan = '{ {1'b0, 5'b11000, H_LU},
              {1'b0, 5'b01000, FIF},
              {1'b0, 5'b00000, NONE} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL branch step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL branch step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_mul();
    plan = '{ {1'b0, 5'b00100, H_MUL},
              {1'b0, 5'b11100, H_MUL | BSY},
              {1'b0, 5'b01000, H_MUL | BSY},
              {1'b0, 5'b00000, H_MUL | BSY},
              {1'b0, 5'b01000, BSY},
              {1'b0, 5'b00000, NONE},
              {1'b0, 5'b01000, FIF} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL mul step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL mul step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_mem();
    plan = '{ {1'b0, 5'b10110, H_MEM},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00011, BSY},
              {1'b0, 5'b00000, NONE},
              {1'b0, 5'b00011, NONE} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL mem step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL mem step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_mul_mem();
    plan = '{ {1'b0, 5'b00100, H_MUL},
              {1'b0, 5'b00000, H_MUL | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00010, H_MEM | BSY},
              {1'b0, 5'b00011, BSY},
              {1'b0, 5'b00000, NONE},
              {1'b0, 5'b01000, FIF} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL mul_mem step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL mul_mem step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_saturation();
    plan.delete();
    plan.push_back({1'b0, 5'b00010, H_MEM});
    for (int k = 0; k < 17; k++) plan.push_back({1'b0, 5'b00010, H_MEM | BSY});
    plan.push_back({1'b0, 5'b00011, BSY});
    plan.push_back({1'b0, 5'b00000, NONE});
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL saturation step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL saturation step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  task automatic test_reset_abort();
    plan = '{ {1'b0, 5'b00100, H_MUL},
              {1'b0, 5'b00000, H_MUL | BSY},
              {1'b1, 5'b10110, NONE},
              {1'b0, 5'b00000, NONE},
              {1'b0, 5'b01000, FIF},
              {1'b0, 5'b10000, H_LU},
              {1'b0, 5'b00000, NONE} };
    for (int i = 0; i < plan.size(); i++) begin
      drive(plan[i]);
      #2;
      e = exp_q.pop_front(); s = sc_q.pop_front(); got = outs();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL reset_abort step %0d: outputs %b, required %b", i, got, e); end
      n_vec++;
      if (stall_cycles !== s) begin n_err++; $display("FAIL reset_abort step %0d: stall_cycles %0d, required %0d", i, stall_cycles, s); end
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    load_use = 1'b0; branch_taken = 1'b0; mul_start = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_mem();
    test_mul_mem();
    test_saturation();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
